calendar_dow_tracker: RTL and testbench
=======================================

// Module: calendar_dow_tracker
// PURPOSE
//   Sequential calendar unit for the digital clock: holds the current date
//   (year/month/day) and its day of week. A date load is validated, then the
//   weekday is computed by a multicycle Zeller datapath with no divider.
//   day_tick advances the date with month, year and leap rollover.
//   Sits between the timekeeping counter (day_tick source) and the display.
// PARAMETERS
//   YEAR_W  12  year width in bits, legal range 8..16; years 1..2^YEAR_W-1
// PORTS
//   clk        in   1       system clock, rising edge
//   rst_n      in   1       synchronous reset, active low
//   load       in   1       request to load year_in/month_in/day_in (1-cycle pulse)
//   year_in    in   YEAR_W  full year, e.g. 2024
//   month_in   in   4       1..12
//   day_in     in   5       1..31
//   day_tick   in   1       advance the date by one day (1-cycle pulse)
//   year_o     out  YEAR_W  current year
//   month_o    out  4       current month
//   day_o      out  5       current day
//   dow        out  3       0=Sat 1=Sun 2=Mon 3=Tue 4=Wed 5=Thu 6=Fri
//   valid      out  1       date and dow are coherent
//   busy       out  1       weekday computation in progress
//   load_err   out  1       1-cycle pulse: load rejected
//   tick_drop  out  1       1-cycle pulse: a day_tick was discarded
//   overflow   out  1       1-cycle pulse: tick at last representable date
// BEHAVIOUR
// - Reset (rst_n=0 at an edge)
//   - year_o=0, month_o=1, day_o=1, dow=0; all flags 0; state IDLE; pend=0.
// - Load validation
//   - Load is rejected when any of these holds: year_in=0, month_in outside
//     1..12, day_in=0, or day_in > days_in_month(year, month).
//   - A rejected load pulses load_err on the next cycle. No other state changes.
//   - Leap year: divisible by 4, and not by 100 unless also by 400.
// - FSM states: IDLE, CALC, RED
//   - Accepted load (any state): date registers take the inputs. Then
//     valid=0, busy=1, pend=0, and the FSM goes to CALC.
//   - A load during CALC or RED aborts the run in progress and restarts.
//   - CALC (1 cycle)
//     - For month 1 or 2: Y=year-1 and M=month+12. Otherwise Y=year, M=month.
//     - Computes S = d + (26*(M+1))/10 + Y + Y>>2 + 6*(Y/100) + Y/400.
//     - S is held in a YEAR_W+2 bit register.
//     - Only constant divisors are used.
//   - RED (YEAR_W cycles, k = YEAR_W-1 down to 0)
//     - Each cycle: if S >= 7<<k, then S -= 7<<k.
//     - After k=0: dow=S[2:0], valid=1, busy=0, FSM returns to IDLE.
//   - Latency: busy is high for exactly YEAR_W+1 cycles after the accepting edge.
//     valid rises on the edge after the last RED cycle.
// - day_tick rules
//   - Tick in IDLE with valid=1: takes effect on the same edge.
//     - day_o increments.
//     - At the end of the month: day_o=1 and month_o increments.
//     - At December 31: month_o=1 and year_o increments.
//     - dow = (dow==6) ? 0 : dow+1.
//   - Tick in IDLE with valid=0 (after reset): ignored, tick_drop pulses.
//   - Tick while busy: stored in a one-deep pend flag.
//     - It is applied in the IDLE cycle after valid rises.
//     - A further tick while pend=1 is discarded and pulses tick_drop.
//   - Tick on the same edge as an accepted load: load wins, tick_drop pulses.
//   - Tick at 12-31 of year 2^YEAR_W-1: date unchanged, overflow pulses,
//     valid stays 1.
// - Simultaneous events: reset beats load, and load beats tick. The reset value
//   applies on any edge where rst_n=0, including in the middle of a RED run.
// TESTING
//   Defaults (YEAR_W=12) unless noted.
//   1. Load 2024-02-29 -> busy for 13 cycles, then valid=1 and dow=5 (Thu).
//   2. Load 2023-12-31, wait for valid (dow=1), then tick -> 2024-01-01, dow=2.
//   3. Load 1900-02-28 and tick -> 1900-03-01.
//      Load 2000-02-28 and tick -> 2000-02-29.
//   4. Load 2023-02-29, then month 13, then year 0
//      -> each gives a load_err pulse; registers unchanged.
//   5. Two ticks during busy after loading 2024-01-31
//      -> one tick_drop pulse; the date after completion is 2024-02-01.
//   6. Load 4095-12-31, then tick -> overflow pulse; date held.
//      Separately, assert rst_n=0 during RED -> all outputs take reset values.

Source files
------------

// File: rtl/calendar_dow_tracker_if.sv
// Calendar bus: date load/tick requests toward the tracker, date/weekday/status back out.
interface calendar_dow_tracker_if #(
  parameter int unsigned YEAR_W = 12
) ();
  logic              load;
  logic [YEAR_W-1:0] year_in;
  logic [3:0]        month_in;
  logic [4:0]        day_in;
  logic              day_tick;
  logic [YEAR_W-1:0] year_o;
  logic [3:0]        month_o;
  logic [4:0]        day_o;
  logic [2:0]        dow;
  logic              valid;
  logic              busy;
  logic              load_err;
  logic              tick_drop;
  logic              overflow;

  modport master (
    output load, year_in, month_in, day_in, day_tick,
    input  year_o, month_o, day_o, dow, valid, busy, load_err, tick_drop, overflow
  );

  modport slave (
    input  load, year_in, month_in, day_in, day_tick,
    output year_o, month_o, day_o, dow, valid, busy, load_err, tick_drop, overflow
  );
endinterface

// File: rtl/calendar_dow_tracker.sv
// Calendar date register with day-of-week tracking. A validated load starts a
// Zeller weekday computation: one cycle forms the raw sum, then YEAR_W
// restoring-subtract steps reduce it modulo 7. day_tick advances the date.
module calendar_dow_tracker #(
  parameter int unsigned YEAR_W = 12
) (
  input logic                   clk,
  input logic                   rst_n,
  calendar_dow_tracker_if.slave bus
);
  localparam int unsigned SW = YEAR_W + 2;
  localparam int unsigned KW = $clog2(YEAR_W);
  localparam logic [KW-1:0] KTop = KW'(YEAR_W - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StRed} state_e;

  state_e            r_state;
  logic [YEAR_W-1:0] r_year;
  logic [3:0]        r_month;
  logic [4:0]        r_day;
  logic [2:0]        r_dow;
  logic              r_valid, r_busy, r_pend;
  logic              r_load_err, r_tick_drop, r_overflow;
  logic [SW-1:0]     r_s;
  logic [KW-1:0]     r_k;

  logic              w_load_ok, w_at_max;
  logic [4:0]        w_cur_dim;
  logic [YEAR_W-1:0] w_next_year;
  logic [3:0]        w_next_month;
  logic [4:0]        w_next_day;
  logic [2:0]        w_next_dow;
  logic [SW-1:0]     w_zy, w_zm, w_s_calc, w_s_red;
  logic [SW:0]       w_sub;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    logic [31:0] yy;
    yy = 32'(y);
    return ((yy % 32'd4) == 32'd0) &&
           (((yy % 32'd100) != 32'd0) || ((yy % 32'd400) == 32'd0));
  endfunction

  function automatic logic [4:0] days_in_month(input logic [YEAR_W-1:0] y,
                                               input logic [3:0] m);
    logic [4:0] dim;
    case (m)
      4'd2:                     dim = is_leap(y) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      default:                  dim = 5'd31;
    endcase
    return dim;
  endfunction

  // Load validation, next-date increment, Zeller sum and one mod-7 reduction step.
  always_comb begin
    w_load_ok = (bus.year_in != '0) && (bus.month_in >= 4'd1) && (bus.month_in <= 4'd12) &&
                (bus.day_in != '0) &&
                (bus.day_in <= days_in_month(bus.year_in, bus.month_in));

    w_cur_dim    = days_in_month(r_year, r_month);
    w_at_max     = (r_year == '1) && (r_month == 4'd12) && (r_day == 5'd31);
    w_next_year  = r_year;
    w_next_month = r_month;
    w_next_day   = r_day + 5'd1;
    if (r_day >= w_cur_dim) begin
      w_next_day = 5'd1;
      if (r_month == 4'd12) begin
        w_next_month = 4'd1;
        w_next_year  = r_year + YEAR_W'(1);
      end else begin
        w_next_month = r_month + 4'd1;
      end
    end
    w_next_dow = (r_dow == 3'd6) ? 3'd0 : r_dow + 3'd1;

    // January/February count as months 13/14 of the previous year.
    if (r_month <= 4'd2) begin
      w_zy = SW'(r_year) - SW'(1);
      w_zm = SW'(r_month) + SW'(12);
    end else begin
      w_zy = SW'(r_year);
      w_zm = SW'(r_month);
    end
    // 6*(Y/100) stands in for -(Y/100) modulo 7, keeping the sum non-negative.
    w_s_calc = SW'(r_day) + (SW'(26) * (w_zm + SW'(1))) / SW'(10) + w_zy + (w_zy >> 2) +
               SW'(6) * (w_zy / SW'(100)) + w_zy / SW'(400);

    w_sub = (SW + 1)'(7) << r_k;
    if ({1'b0, r_s} >= w_sub) w_s_red = r_s - w_sub[SW-1:0];
    else                      w_s_red = r_s;
  end

  // Calendar FSM: load/abort, Zeller sum, mod-7 reduction, tick handling, flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_year      <= '0;
      r_month     <= 4'd1;
      r_day       <= 5'd1;
      r_dow       <= 3'd0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_pend      <= 1'b0;
      r_load_err  <= 1'b0;
      r_tick_drop <= 1'b0;
      r_overflow  <= 1'b0;
      r_s         <= '0;
      r_k         <= '0;
    end else begin
      r_load_err  <= 1'b0;
      r_tick_drop <= 1'b0;
      r_overflow  <= 1'b0;
      if (bus.load && w_load_ok) begin
        r_year      <= bus.year_in;
        r_month     <= bus.month_in;
        r_day       <= bus.day_in;
        r_valid     <= 1'b0;
        r_busy      <= 1'b1;
        r_pend      <= 1'b0;
        r_state     <= StCalc;
        r_tick_drop <= bus.day_tick;
      end else begin
        if (bus.load) r_load_err <= 1'b1;
        unique case (r_state)
          StIdle: begin
            if (r_valid && (bus.day_tick || r_pend)) begin
              // A pending tick takes this slot; a simultaneous fresh tick is lost.
              r_pend      <= 1'b0;
              r_tick_drop <= bus.day_tick && r_pend;
              if (w_at_max) begin
                r_overflow <= 1'b1;
              end else begin
                r_year  <= w_next_year;
                r_month <= w_next_month;
                r_day   <= w_next_day;
                r_dow   <= w_next_dow;
              end
            end else if (bus.day_tick) begin
              r_tick_drop <= 1'b1;
            end
          end
          StCalc, StRed: begin
            if (bus.day_tick) begin
              if (r_pend) r_tick_drop <= 1'b1;
              else        r_pend      <= 1'b1;
            end
            if (r_state == StCalc) begin
              r_s     <= w_s_calc;
              r_k     <= KTop;
              r_state <= StRed;
            end else begin
              r_s <= w_s_red;
              if (r_k == '0) begin
                r_dow   <= w_s_red[2:0];
                r_valid <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= StIdle;
              end else begin
                r_k <= r_k - KW'(1);
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.year_o    = r_year;
  assign bus.month_o   = r_month;
  assign bus.day_o     = r_day;
  assign bus.dow       = r_dow;
  assign bus.valid     = r_valid;
  assign bus.busy      = r_busy;
  assign bus.load_err  = r_load_err;
  assign bus.tick_drop = r_tick_drop;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_calendar_dow_tracker.sv
// Bench for calendar_dow_tracker: directed cases with hand-computed answers, then
// random loads/ticks/resets checked every cycle against a day-count calendar model.
module tb_calendar_dow_tracker;
  localparam int YW   = 12;
  localparam int YMAX = (1 << YW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calendar_dow_tracker_if #(.YEAR_W(YW)) bus ();

  calendar_dow_tracker #(.YEAR_W(YW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- reference calendar ----------------
  function automatic bit leap(input int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int dim(input int y, input int m);
    if (m == 2) return leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic bit legal(input int y, input int m, input int d);
    return (y > 0) && (m >= 1) && (m <= 12) && (d >= 1) && (d <= dim(y, m));
  endfunction

  // Days since 0001-01-01 (a Monday, code 2 with 0=Sat).
  function automatic int ref_dow(input int y, input int m, input int d);
    int days;
    days = (y - 1) * 365 + (y - 1) / 4 - (y - 1) / 100 + (y - 1) / 400 + d - 1;
    for (int i = 1; i < m; i++) days += dim(y, i);
    return (days + 2) % 7;
  endfunction

  // Inputs as seen by the DUT at each rising edge.
  bit s_rst_n, s_load, s_tick;
  int s_y, s_m, s_d;
  always @(posedge clk) begin
    s_rst_n <= rst_n;
    s_load  <= bus.load;
    s_tick  <= bus.day_tick;
    s_y     <= int'(bus.year_in);
    s_m     <= int'(bus.month_in);
    s_d     <= int'(bus.day_in);
  end

  int m_year, m_month, m_day, m_dow, m_cnt;
  bit m_valid, m_pend, m_lerr, m_tdrop, m_ovf;

  task automatic model_step();
    m_lerr  = 1'b0;
    m_tdrop = 1'b0;
    m_ovf   = 1'b0;
    if (!s_rst_n) begin
      m_year = 0; m_month = 1; m_day = 1; m_dow = 0;
      m_valid = 1'b0; m_cnt = 0; m_pend = 1'b0;
    end else if (s_load && legal(s_y, s_m, s_d)) begin
      m_year = s_y; m_month = s_m; m_day = s_d;
      m_valid = 1'b0; m_pend = 1'b0; m_cnt = YW + 1;
      m_tdrop = s_tick;
    end else begin
      m_lerr = s_load;
      if (m_cnt > 0) begin
        if (s_tick) begin
          if (m_pend) m_tdrop = 1'b1;
          else        m_pend  = 1'b1;
        end
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_dow   = ref_dow(m_year, m_month, m_day);
        end
      end else if (m_valid && (s_tick || m_pend)) begin
        m_tdrop = s_tick && m_pend;
        m_pend  = 1'b0;
        if (m_year == YMAX && m_month == 12 && m_day == 31) begin
          m_ovf = 1'b1;
        end else begin
          m_day++;
          if (m_day > dim(m_year, m_month)) begin
            m_day = 1;
            m_month++;
            if (m_month > 12) begin
              m_month = 1;
              m_year++;
            end
          end
          m_dow = ref_dow(m_year, m_month, m_day);
        end
      end else if (s_tick) begin
        m_tdrop = 1'b1;
      end
    end
  endtask

  // Compare process: advance the model, then check every output.
  always @(negedge clk) begin
    model_step();
    if (check_en) begin
      chk("year",      int'(bus.year_o),    m_year);
      chk("month",     int'(bus.month_o),   m_month);
      chk("day",       int'(bus.day_o),     m_day);
      chk("dow",       int'(bus.dow),       m_dow);
      chk("valid",     int'(bus.valid),     int'(m_valid));
      chk("busy",      int'(bus.busy),      (m_cnt > 0) ? 1 : 0);
      chk("load_err",  int'(bus.load_err),  int'(m_lerr));
      chk("tick_drop", int'(bus.tick_drop), int'(m_tdrop));
      chk("overflow",  int'(bus.overflow),  int'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit ld, input int y, input int m, input int d, input bit tk);
    bus.load     = ld;
    bus.year_in  = YW'(y);
    bus.month_in = 4'(m);
    bus.day_in   = 5'(d);
    bus.day_tick = tk;
    @(negedge clk);
    bus.load     = 1'b0;
    bus.day_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("busy_timeout", int'(bus.busy), 0);
  endtask

  task automatic chk_date(input string name, input int y, input int m, input int d);
    chk({name, "_year"},  int'(bus.year_o),  y);
    chk({name, "_month"}, int'(bus.month_o), m);
    chk({name, "_day"},   int'(bus.day_o),   d);
  endtask

  task automatic rand_date(output int y, output int m, output int d);
    int r;
    r = $urandom_range(0, 9);
    y = (r < 3) ? $urandom_range(YMAX - 5, YMAX) : $urandom_range(1, YMAX);
    m = ($urandom_range(0, 3) == 0) ? 12 : $urandom_range(1, 12);
    case ($urandom_range(0, 3))
      0:       d = dim(y, m);
      1:       d = dim(y, m) - 1;
      default: d = $urandom_range(1, dim(y, m));
    endcase
    if ($urandom_range(0, 5) == 0) begin
      case ($urandom_range(0, 3))
        0:       y = 0;
        1:       m = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(13, 15);
        2:       d = 0;
        default: d = (dim(y, m) < 31) ? dim(y, m) + 1 : 0;
      endcase
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int y, m, d;
    bit ld, tk;

    bus.load = 1'b0; bus.day_tick = 1'b0;
    bus.year_in = '0; bus.month_in = '0; bus.day_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    chk_date("reset", 0, 1, 1);
    chk("reset_dow",   int'(bus.dow),   0);
    chk("reset_valid", int'(bus.valid), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2024-02-29 is a Thursday; busy spans 13 cycles.
    drive(1'b1, 2024, 2, 29, 1'b0);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", n, 13);
    chk("t1_valid", int'(bus.valid), 1);
    chk("t1_dow",   int'(bus.dow),   5);

    // Year rollover: 2023-12-31 Sunday -> 2024-01-01 Monday.
    drive(1'b1, 2023, 12, 31, 1'b0);
    wait_idle();
    chk("t2_dow", int'(bus.dow), 1);
    drive(1'b0, 0, 0, 0, 1'b1);
    chk_date("t2", 2024, 1, 1);
    chk("t2_dow_next", int'(bus.dow), 2);

    // Century leap rules.
    drive(1'b1, 1900, 2, 28, 1'b0);
    wait_idle();
    drive(1'b0, 0, 0, 0, 1'b1);
    chk_date("t3_1900", 1900, 3, 1);
    drive(1'b1, 2000, 2, 28, 1'b0);
    wait_idle();
    drive(1'b0, 0, 0, 0, 1'b1);
    chk_date("t3_2000", 2000, 2, 29);

    // Rejected loads leave the date alone.
    drive(1'b1, 2023, 2, 29, 1'b0);
    chk("t4_err_feb29", int'(bus.load_err), 1);
    chk_date("t4_a", 2000, 2, 29);
    drive(1'b1, 2023, 13, 1, 1'b0);
    chk("t4_err_m13", int'(bus.load_err), 1);
    drive(1'b1, 0, 1, 1, 1'b0);
    chk("t4_err_y0", int'(bus.load_err), 1);
    chk_date("t4_b", 2000, 2, 29);
    chk("t4_valid", int'(bus.valid), 1);

    // Two ticks while busy: one pends, one drops.
    drive(1'b1, 2024, 1, 31, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1);
    chk("t5_no_drop", int'(bus.tick_drop), 0);
    drive(1'b0, 0, 0, 0, 1'b1);
    chk("t5_drop", int'(bus.tick_drop), 1);
    wait_idle();
    chk("t5_dow_jan31", int'(bus.dow), 4);
    @(negedge clk);
    chk_date("t5", 2024, 2, 1);
    chk("t5_dow", int'(bus.dow), 5);

    // Last representable date.
    drive(1'b1, YMAX, 12, 31, 1'b0);
    wait_idle();
    drive(1'b0, 0, 0, 0, 1'b1);
    chk("t6_overflow", int'(bus.overflow), 1);
    chk_date("t6", YMAX, 12, 31);
    chk("t6_valid", int'(bus.valid), 1);

    // Reset in the middle of the reduction.
    drive(1'b1, 2024, 2, 29, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_date("t6_rst", 0, 1, 1);
    chk("t6_rst_busy",  int'(bus.busy),  0);
    chk("t6_rst_valid", int'(bus.valid), 0);
    chk("t6_rst_dow",   int'(bus.dow),   0);

    // Random phase.
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      #1;
      ld = ($urandom_range(0, 39) == 0);
      tk = ($urandom_range(0, 2) == 0);
      y = 0; m = 0; d = 0;
      if (ld) rand_date(y, m, d);
      if (ld && !legal(y, m, d)) tk = 1'b0;
      if (m_cnt == 0 && m_pend) tk = 1'b0;
      rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
      bus.load     = ld;
      bus.year_in  = YW'(y);
      bus.month_in = 4'(m);
      bus.day_in   = 5'(d);
      bus.day_tick = tk;
    end
    @(negedge clk);
    #1;
    bus.load = 1'b0;
    bus.day_tick = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
